// File: rtl/if_control_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// if_control_unit
//
// Instruction-fetch stage. Owns the PC, drives the instruction-memory address
// and registers {IC, PPCCB, PC, Valid, IR} into the IF/ID pipeline register
// consumed by decode. Branch prediction uses a direct-mapped BTB of 2-bit
// saturating counters. The BTB is built only when IF_BTB_EN is defined;
// without it the stage fetches sequentially and ignores branch updates.
//
// Ports:
//   Clk, reset               clock (rising edge), async active-high reset
//   stall, flush             hazard-unit controls (hold / squash IF/ID)
//   iRedirect, iRedirectPC   misprediction redirect from execute
//   iBPUpdate, iBPPC,
//   iBPTaken, iBPTarget      resolved-branch BTB training
//   oIMemAddr / iIMemData    instruction memory (combinational read)
//   oIC, oPPCCB, oPC,
//   oValid, oIR              IF/ID register contents
//
// Valid/ready: there is no handshake. A fetched word moves into IF/ID on any
// edge where stall is low; stall holds PC and IF/ID, flush or iRedirect
// squash IF/ID, and iRedirect takes priority over stall.
// -----------------------------------------------------------------------------
module if_control_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16,
  parameter int          IC_W        = 16
) (
  input  logic            Clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            iRedirect,
  input  logic [31:0]     iRedirectPC,
  input  logic            iBPUpdate,
  input  logic [31:0]     iBPPC,
  input  logic            iBPTaken,
  input  logic [31:0]     iBPTarget,
  output logic [31:0]     oIMemAddr,
  input  logic [31:0]     iIMemData,
  output logic [IC_W-1:0] oIC,
  output logic [1:0]      oPPCCB,
  output logic [31:0]     oPC,
  output logic            oValid,
  output logic [31:0]     oIR
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0]     pc_q, pc_d;
  logic [IC_W-1:0] ic_cnt_q;

  // Prediction for the word currently addressed by pc_q.
  logic            pred_taken;
  logic [1:0]      pred_ctr;
  logic [31:0]     pred_target;

`ifdef IF_BTB_EN
  logic             btb_valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_q    [BTB_ENTRIES];
  logic [31:0]      btb_target_q [BTB_ENTRIES];
  logic [1:0]       btb_ctr_q    [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic [1:0]       up_ctr_cur, up_ctr_new;

  assign lk_idx = pc_q[IDX_W+1:2];
  assign lk_tag = pc_q[31:IDX_W+2];
  assign up_idx = iBPPC[IDX_W+1:2];
  assign up_tag = iBPPC[31:IDX_W+2];

  assign lk_hit = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
  assign up_hit = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);

  // Lookup reads the registered arrays, so a same-cycle update to the same
  // entry is only visible from the next cycle on.
  always_comb begin
    pred_ctr    = lk_hit ? btb_ctr_q[lk_idx] : 2'b01;
    pred_taken  = lk_hit && btb_ctr_q[lk_idx][1];
    pred_target = btb_target_q[lk_idx];
  end

  // Saturating counter step for a hit update.
  always_comb begin
    up_ctr_cur = btb_ctr_q[up_idx];
    up_ctr_new = up_ctr_cur;
    if (iBPTaken) begin
      if (up_ctr_cur != 2'b11) up_ctr_new = up_ctr_cur + 2'd1;
    end else begin
      if (up_ctr_cur != 2'b00) up_ctr_new = up_ctr_cur - 2'd1;
    end
  end

  // Training runs regardless of stall/flush.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
        btb_ctr_q[i]    <= 2'b01;
      end
    end else if (iBPUpdate) begin
      if (up_hit) begin
        btb_ctr_q[up_idx] <= up_ctr_new;
        if (iBPTaken) btb_target_q[up_idx] <= iBPTarget;
      end else if (iBPTaken) begin
        // Miss + taken: allocate (or replace an aliasing entry) weakly taken.
        btb_valid_q[up_idx]  <= 1'b1;
        btb_tag_q[up_idx]    <= up_tag;
        btb_target_q[up_idx] <= iBPTarget;
        btb_ctr_q[up_idx]    <= 2'b10;
      end
    end
  end

  // Byte-offset bits of a branch PC carry no index or tag information.
  logic unused_bp_lsbs;
  assign unused_bp_lsbs = ^iBPPC[1:0];
`else
  assign pred_taken  = 1'b0;
  assign pred_ctr    = 2'b01;
  assign pred_target = '0;

  logic unused_bp_inputs;
  assign unused_bp_inputs = ^{iBPUpdate, iBPPC, iBPTaken, iBPTarget};
`endif

  // Next-PC selection: redirect, then stall, then prediction, then PC+4.
  always_comb begin
    if (iRedirect)       pc_d = iRedirectPC;
    else if (stall)      pc_d = pc_q;
    else if (pred_taken) pc_d = pred_target;
    else                 pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign oIMemAddr = pc_q;

  // IF/ID register. A squash still captures the current fetch into the
  // side fields so they never hold stale data; only Valid/IR are cleared.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      oValid   <= 1'b0;
      oIR      <= '0;
      oPC      <= '0;
      oPPCCB   <= 2'b01;
      oIC      <= '0;
      ic_cnt_q <= '0;
    end else if (iRedirect || flush) begin
      oValid <= 1'b0;
      oIR    <= '0;
      oPC    <= pc_q;
      oPPCCB <= pred_ctr;
      oIC    <= ic_cnt_q;
    end else if (!stall) begin
      oValid   <= 1'b1;
      oIR      <= iIMemData;
      oPC      <= pc_q;
      oPPCCB   <= pred_ctr;
      oIC      <= ic_cnt_q;
      ic_cnt_q <= ic_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_control_unit.sv
`timescale 1ns/1ps
module tb_if_control_unit;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          BTB_ENTRIES = 16;
  localparam int          IC_W        = 4;
`ifdef IF_BTB_EN
  localparam bit BTB_EN = 1'b1;
`else
  localparam bit BTB_EN = 1'b0;
`endif

  // ---------------------------------------------------------------- clock/reset
  logic Clk = 1'b0;
  logic reset;
  always #5 Clk = ~Clk;

  logic            stall, flush, iRedirect, iBPUpdate, iBPTaken;
  logic [31:0]     iRedirectPC, iBPPC, iBPTarget, oIMemAddr, iIMemData, oPC, oIR;
  logic [IC_W-1:0] oIC;
  logic [1:0]      oPPCCB;
  logic            oValid;

  int n_vec = 0;
  int n_err = 0;

  if_control_unit #(
    .RESET_PC(RESET_PC), .BTB_ENTRIES(BTB_ENTRIES), .IC_W(IC_W)
  ) dut (
    .Clk(Clk), .reset(reset), .stall(stall), .flush(flush),
    .iRedirect(iRedirect), .iRedirectPC(iRedirectPC),
    .iBPUpdate(iBPUpdate), .iBPPC(iBPPC), .iBPTaken(iBPTaken), .iBPTarget(iBPTarget),
    .oIMemAddr(oIMemAddr), .iIMemData(iIMemData),
    .oIC(oIC), .oPPCCB(oPPCCB), .oPC(oPC), .oValid(oValid), .oIR(oIR)
  );

  // Memory contents: a tagged word address, distinguishable from the PC.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) ^ 32'hC0DE_0000;
  endfunction
  assign iIMemData = mem_word(oIMemAddr);

  // ---------------------------------------------------------- reference model
  logic [31:0] m_pc, m_ir, m_pcout;
  bit          m_valid;
  int          m_ppccb;
  int unsigned m_icout, m_cnt;
  bit          b_valid  [BTB_ENTRIES];
  logic [31:0] b_tag    [BTB_ENTRIES];
  logic [31:0] b_target [BTB_ENTRIES];
  int          b_ctr    [BTB_ENTRIES];

  task automatic model_reset();
    m_pc = RESET_PC; m_valid = 0; m_ir = 0; m_pcout = 0; m_ppccb = 1;
    m_icout = 0; m_cnt = 0;
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      b_valid[i] = 0; b_tag[i] = 0; b_target[i] = 0; b_ctr[i] = 1;
    end
  endtask

  // --------------------------------------------------------------- scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("imem_addr", oIMemAddr, m_pc);
    check("valid", {31'b0, oValid}, {31'b0, m_valid});
    check("ir", oIR, m_ir);
    if (m_valid) begin
      check("pc", oPC, m_pcout);
      check("ic", {{(32-IC_W){1'b0}}, oIC}, m_icout);
      check("ppccb", {30'b0, oPPCCB}, m_ppccb);
    end
  endtask

  // One clock: predict from current inputs, advance the model, compare.
  task automatic step();
    int          idx, ctr;
    logic [31:0] tg, npc;
    bit          hit, taken;
    idx   = int'((m_pc >> 2) % BTB_ENTRIES);
    tg    = m_pc / (4 * BTB_ENTRIES);
    hit   = BTB_EN && b_valid[idx] && (b_tag[idx] == tg);
    ctr   = hit ? b_ctr[idx] : 1;
    taken = hit && (ctr >= 2);
    if (iRedirect)  npc = iRedirectPC;
    else if (stall) npc = m_pc;
    else if (taken) npc = b_target[idx];
    else            npc = m_pc + 32'd4;
    if (iRedirect || flush) begin
      m_valid = 0; m_ir = 0;
    end else if (!stall) begin
      m_valid = 1; m_ir = mem_word(m_pc); m_pcout = m_pc; m_ppccb = ctr;
      m_icout = m_cnt; m_cnt = (m_cnt + 1) % (1 << IC_W);
    end
    if (BTB_EN && iBPUpdate) begin
      int          ui;
      logic [31:0] ut;
      ui = int'((iBPPC >> 2) % BTB_ENTRIES);
      ut = iBPPC / (4 * BTB_ENTRIES);
      if (b_valid[ui] && b_tag[ui] == ut) begin
        if (iBPTaken) begin
          b_ctr[ui] = (b_ctr[ui] < 3) ? b_ctr[ui] + 1 : 3;
          b_target[ui] = iBPTarget;
        end else begin
          b_ctr[ui] = (b_ctr[ui] > 0) ? b_ctr[ui] - 1 : 0;
        end
      end else if (iBPTaken) begin
        b_valid[ui] = 1; b_tag[ui] = ut; b_target[ui] = iBPTarget; b_ctr[ui] = 2;
      end
    end
    m_pc = npc;
    @(posedge Clk);
    #1;
    check_outputs();
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic idle_inputs();
    stall = 0; flush = 0; iRedirect = 0; iRedirectPC = 0;
    iBPUpdate = 0; iBPPC = 0; iBPTaken = 0; iBPTarget = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    iRedirect = 1; iRedirectPC = pc;
    step();
    iRedirect = 0;
  endtask

  task automatic bp_update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    iBPUpdate = 1; iBPPC = pc; iBPTaken = tk; iBPTarget = tgt;
    step();
    iBPUpdate = 0;
  endtask

  task automatic check_reset_state();
    check("rst_imem_addr", oIMemAddr, RESET_PC);
    check("rst_valid", {31'b0, oValid}, 32'd0);
    check("rst_ir", oIR, 32'd0);
    check("rst_pc", oPC, 32'd0);
    check("rst_ppccb", {30'b0, oPPCCB}, 32'd1);
    check("rst_ic", {{(32-IC_W){1'b0}}, oIC}, 32'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    idle_inputs();
    reset = 1;
    model_reset();
    #12;
    check_reset_state();
    @(posedge Clk); #1;
    reset = 0;

    // Sequential fetch from reset, passes 0x10 then stalls there.
    run(4);
    stall = 1;
    run(3);
    stall = 0;
    run(20);                 // long enough to wrap the 4-bit IC counter

    // Redirect overrides a concurrent stall.
    stall = 1;
    redirect_to(32'h0000_0200);
    stall = 0;
    run(3);

    // Flush squashes one slot without disturbing the PC sequence.
    flush = 1;
    step();
    flush = 0;
    run(2);

    // BTB training: taken at 0x40 -> 0x100, then weaken to strongly not-taken.
    bp_update(32'h0000_0040, 1'b1, 32'h0000_0100);
    redirect_to(32'h0000_0038);
    run(5);
    bp_update(32'h0000_0040, 1'b0, 32'h0000_0000);
    bp_update(32'h0000_0040, 1'b0, 32'h0000_0000);
    redirect_to(32'h0000_003C);
    run(4);

    // Aliasing: 0x80 shares the index of 0x40 with a different tag.
    bp_update(32'h0000_0040, 1'b1, 32'h0000_0100);
    bp_update(32'h0000_0040, 1'b1, 32'h0000_0100);
    redirect_to(32'h0000_0080);
    run(3);

    // Update and lookup of the same entry in the same cycle.
    redirect_to(32'h0000_0050);
    iBPUpdate = 1; iBPPC = 32'h0000_0050; iBPTaken = 1; iBPTarget = 32'h0000_0300;
    step();
    iBPUpdate = 0;
    redirect_to(32'h0000_0050);
    run(3);

    // PC wraps modulo 2^32.
    redirect_to(32'hFFFF_FFF8);
    run(4);

    // Mid-stream reset with the BTB trained: immediate squash, BTB cleared.
    redirect_to(32'h0000_003C);
    run(2);
    reset = 1;
    #1;
    model_reset();
    check("midrst_valid", {31'b0, oValid}, 32'd0);
    check("midrst_imem_addr", oIMemAddr, RESET_PC);
    @(posedge Clk); #1;
    reset = 0;
    redirect_to(32'h0000_003C);
    run(4);

    // Randomised traffic over a small address window so BTB entries collide.
    for (int i = 0; i < 500; i++) begin
      stall       = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      iRedirect   = ($urandom_range(0, 9) == 0);
      iRedirectPC = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFF8
                                                 : {$urandom_range(0, 127), 2'b00};
      iBPUpdate   = ($urandom_range(0, 2) == 0);
      iBPPC       = {$urandom_range(0, 127), 2'b00};
      iBPTaken    = $urandom_range(0, 1) == 1;
      iBPTarget   = {$urandom_range(0, 127), 2'b00};
      step();
    end
    idle_inputs();
    run(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_control_unit.md
Name: if_control_unit

Overview:
- Instruction-fetch stage, directly upstream of the decode stage.
- Owns the PC register, drives the instruction-memory address and predicts taken branches with a direct-mapped BTB of 2-bit saturating counters.
- Registers {IC, PPCCB, PC, Valid, IR} into the IF/ID pipeline register consumed by decode.
- Accepts stall/flush from the hazard unit and redirects from execute.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- BTB_ENTRIES, 16, BTB entry count; power of 2, 4..256.
- IC_W, 16, width of fetch sequence number oIC.

Ports:
- Clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and IF/ID register.
- flush  in  1  squash IF/ID contents (Valid=0).
- iRedirect  in  1  execute resolved a misprediction.
- iRedirectPC  in  32  correct next fetch address.
- iBPUpdate  in  1  branch resolved; update BTB.
- iBPPC  in  32  PC of the resolved branch.
- iBPTaken  in  1  actual outcome.
- iBPTarget  in  32  actual target.
- oIMemAddr  out  32  instruction-memory address; equals the PC register.
- iIMemData  in  32  instruction word, combinational read of oIMemAddr.
- oIC  out  IC_W  fetch sequence number.
- oPPCCB  out  2  BTB counter used for the prediction; bit1 = predicted taken.
- oPC  out  32  PC of the instruction in IF/ID.
- oValid  out  1  IF/ID holds a real instruction.
- oIR  out  32  instruction word.

Behaviour:
- Reset, asynchronous:
  - PC = RESET_PC.
  - oValid = 0, oIR = 0, oPC = 0, oPPCCB = 2'b01, oIC = 0.
  - All BTB valid bits = 0; counters = 2'b01.
- BTB lookup:
  - Index = PC[log2(BTB_ENTRIES)+1:2]; tag = remaining upper PC bits.
  - Hit = entry valid and tag match.
  - Predict taken when hit and counter[1]=1.
  - On a miss the prediction counter is 2'b01.
- Next-PC priority, highest first:
  1. iRedirect → iRedirectPC.
  2. stall → hold PC.
  3. Predict taken → BTB target.
  4. Otherwise PC+4, wrapping modulo 2^32.
- IF/ID register, each edge, highest priority first:
  1. iRedirect or flush → oValid=0, oIR=0; other fields are don't-care but are loaded with the current fetch.
  2. stall → hold all fields.
  3. Otherwise load {IC counter, prediction counter, PC, 1, iIMemData}.
- iRedirect overrides stall for both PC and IF/ID. Load latency is one cycle from PC to IF/ID.
- IC counter: increments only when IF/ID loads with Valid=1; wraps at 2^IC_W.
- BTB update at the clock edge when iBPUpdate=1, indexed and tagged by iBPPC:
  - Hit: counter saturating +1 if taken, -1 if not; target ← iBPTarget if taken.
  - Miss and taken: allocate/replace with tag, target, counter=2'b10.
  - Miss and not taken: no change.
- Lookup and update at the same index in the same cycle: the lookup uses the pre-update contents.
- BTB updates proceed during stall and flush.
- No other internal state; no FSM beyond the PC, IC counter and BTB.

Optional Feature:
- Macro IF_BTB_EN.
- Defined: BTB implemented as above.
- Undefined:
  - No BTB storage.
  - Next PC is iRedirectPC, held PC, or PC+4 only.
  - oPPCCB is constant 2'b01.
  - iBPUpdate, iBPPC, iBPTaken and iBPTarget are ignored.

Test Plan:
- Reset release, no stalls, memory returns the word address:
  - Required: oPC = 0,4,8,… on consecutive cycles, oValid=1 from the first edge, oIC = 0,1,2,…, oPPCCB=2'b01.
- stall high for 3 cycles at PC=0x10:
  - Required: oIMemAddr holds 0x10, IF/ID fields frozen, oIC unchanged.
  - Required: the sequence resumes at 0x14 after release.
- iRedirect with iRedirectPC=0x200 while stall=1:
  - Required: next oIMemAddr=0x200 and oValid=0.
  - Required: one cycle later oPC=0x200, oValid=1.
- BTB training, IF_BTB_EN defined:
  - Stimulus: iBPUpdate taken for PC 0x40, target 0x100; then fetch reaches 0x40.
  - Required: next oIMemAddr=0x100 and oPPCCB=2'b10.
  - Stimulus: two not-taken updates for PC 0x40.
  - Required: counter 2'b00; fetch of 0x40 falls through to 0x44.
- Aliasing, BTB_ENTRIES=16:
  - Stimulus: taken update for 0x40, then fetch 0x80 (same index, different tag).
  - Required: miss → 0x84, oPPCCB=2'b01.
- Reset asserted mid-stream with the BTB trained:
  - Required: immediate oValid=0 and PC=RESET_PC.
  - Required: a later fetch of 0x40 predicts not taken.
